// File: rtl/core_clock_sequencer.sv
// Clock-enable and reset sequencer: divides the fast clock into a one-cycle core_ce
// strobe, stretches reset over RST_HOLD strobes, counts retired core cycles.
// Optional halt/single-step control is built when CORE_SEQ_STEP_MODE_EN is defined.
module core_clock_sequencer #(
  parameter int DIV_RATIO = 25,
  parameter int RST_HOLD  = 4,
  parameter int CNT_W     = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             halt,
  input  logic             step,
  output logic             core_ce,
  output logic             core_reset,
  output logic [CNT_W-1:0] cycle_count,
  output logic [1:0]       state
);

  localparam int DIV_W  = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
  localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t             r_state, w_state_next;
  logic [DIV_W-1:0]   r_div_cnt;
  logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_next;
  logic               r_core_ce, w_core_ce_next;
  logic               r_core_reset, w_core_reset_next;
  logic [CNT_W-1:0]   r_cycle_count;
  logic               w_tick;

  assign w_tick = (r_div_cnt == DIV_W'(DIV_RATIO - 1));

`ifdef CORE_SEQ_STEP_MODE_EN
  logic r_step_d;
  logic r_step_pending, w_step_pending_next;
  logic w_step_rise;

  assign w_step_rise = step & ~r_step_d;
`else
  logic w_unused_inputs;
  assign w_unused_inputs = halt ^ step;
`endif

  always_comb begin
    w_state_next      = r_state;
    w_hold_cnt_next   = r_hold_cnt;
    w_core_reset_next = r_core_reset;
    w_core_ce_next    = 1'b0;
`ifdef CORE_SEQ_STEP_MODE_EN
    w_step_pending_next = r_step_pending;
`endif
    case (r_state)
      ST_HOLD: begin
        w_core_ce_next = w_tick;
        // The hold pulse is complete on the edge after it was issued.
        if (r_core_ce) begin
          if (r_hold_cnt == HOLD_W'(RST_HOLD - 1)) begin
            w_core_reset_next = 1'b0;
            w_state_next      = ST_RUN;
          end else begin
            w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
          end
        end
      end
      ST_RUN: begin
`ifdef CORE_SEQ_STEP_MODE_EN
        w_core_ce_next = w_tick & ~halt;
        if (halt) begin
          w_state_next = ST_HALTED;
        end
`else
        w_core_ce_next = w_tick;
`endif
      end
`ifdef CORE_SEQ_STEP_MODE_EN
      ST_HALTED: begin
        w_core_ce_next = w_tick & r_step_pending;
        // Releasing halt wins over a coincident step edge.
        if (!halt) begin
          w_state_next        = ST_RUN;
          w_step_pending_next = 1'b0;
        end else if (r_step_pending) begin
          if (w_tick) begin
            w_step_pending_next = 1'b0;
          end
        end else if (w_step_rise) begin
          w_step_pending_next = 1'b1;
        end
      end
`endif
      default: begin
        w_state_next = ST_HOLD;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= ST_HOLD;
      r_div_cnt     <= '0;
      r_hold_cnt    <= '0;
      r_core_ce     <= 1'b0;
      r_core_reset  <= 1'b1;
      r_cycle_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_div_cnt    <= w_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_hold_cnt   <= w_hold_cnt_next;
      r_core_ce    <= w_core_ce_next;
      r_core_reset <= w_core_reset_next;
      if (r_core_ce && (r_state != ST_HOLD)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

`ifdef CORE_SEQ_STEP_MODE_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_step_d       <= 1'b0;
      r_step_pending <= 1'b0;
    end else begin
      r_step_d       <= step;
      r_step_pending <= w_step_pending_next;
    end
  end
`endif

  assign core_ce     = r_core_ce;
  assign core_reset  = r_core_reset;
  assign cycle_count = r_cycle_count;
  assign state       = r_state;

endmodule

// File: tb/tb_core_clock_sequencer.sv
// Directed bench for core_clock_sequencer with DIV_RATIO=4, RST_HOLD=2, CNT_W=4.
// Halt/step scenarios run when CORE_SEQ_STEP_MODE_EN is defined.
module tb_core_clock_sequencer;
  localparam int DIV    = 4;
  localparam int HOLDN  = 2;
  localparam int CW     = 4;
  localparam int RST_FALL = HOLDN * DIV + 1;  // edge 9
`ifdef CORE_SEQ_STEP_MODE_EN
  localparam logic IDLE_HALT = 1'b0;
`else
  localparam logic IDLE_HALT = 1'b1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          halt  = 1'b0;
  logic          step  = 1'b0;
  logic          core_ce;
  logic          core_reset;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state;

  int tests = 0;
  int fails = 0;
  int e     = 0;

  always #5 clock = ~clock;

  core_clock_sequencer #(.DIV_RATIO(DIV), .RST_HOLD(HOLDN), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .halt        (halt),
    .step        (step),
    .core_ce     (core_ce),
    .core_reset  (core_reset),
    .cycle_count (cycle_count),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, e, obs, exp);
    end
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
    e++;
  endtask

  // Normal post-reset waveform: pulses at multiples of DIV, reset falls at edge 9,
  // cycle_count = (e-9)/4 mod 16 once running.
  task automatic run_to(input int last);
    while (e < last) begin
      next_edge();
      check("core_ce", 32'(core_ce), 32'((e % DIV) == 0));
      check("core_reset", 32'(core_reset), 32'(e < RST_FALL));
      check("state", 32'(state), (e < RST_FALL) ? 32'd0 : 32'd1);
      check("cycle_count", 32'(cycle_count), (e < RST_FALL) ? 32'd0 : 32'(((e - RST_FALL) / DIV) % 16));
`ifndef CORE_SEQ_STEP_MODE_EN
      step = ~step;
`endif
    end
  endtask

  task automatic release_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    e = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog edge=%0d", e);
    $fatal(1, "timeout");
  end

  initial begin
    halt  = IDLE_HALT;
    step  = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("rst_core_ce", 32'(core_ce), 32'd0);
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_cycle_count", 32'(cycle_count), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    #2 reset = 1'b0;
    e = 0;
    run_to(17);

`ifdef CORE_SEQ_STEP_MODE_EN
    // Halt sampled at edges 18..30, steps sampled at 21 (taken), 23 (ignored),
    // and 31 together with halt release (halt wins).
    halt = 1'b1;
    while (e < 33) begin
      next_edge();
      check("halt_core_ce", 32'(core_ce), 32'((e == 24) || (e == 32)));
      check("halt_state", 32'(state), (e <= 30) ? 32'd2 : 32'd1);
      check("halt_cycle_count", 32'(cycle_count), (e < 25) ? 32'd2 : ((e < 33) ? 32'd3 : 32'd4));
      halt = (e < 30);
      step = (e == 20) || (e == 22) || (e == 30);
    end
    halt = IDLE_HALT;
    step = 1'b0;
    reset = 1'b1;
    release_reset();
`endif

    // Long run crosses the cycle_count wrap (16 RUN pulses) at edge 73.
    run_to(80);
    #2 reset = 1'b1;
    #1;
    check("async_core_ce", 32'(core_ce), 32'd0);
    check("async_core_reset", 32'(core_reset), 32'd1);
    check("async_cycle_count", 32'(cycle_count), 32'd0);
    check("async_state", 32'(state), 32'd0);
    release_reset();
    run_to(17);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/core_clock_sequencer.md
# core_clock_sequencer

Clock-enable and reset sequencer for the RISC processor. Runs on the fast `clock` and replaces the separate slow processor clock with a one-cycle `core_ce` strobe every `DIV_RATIO` cycles. Stretches `reset` into a `core_reset` held for `RST_HOLD` enabled core edges, and counts retired core cycles. Optionally provides halt/single-step control for bring-up.

## Interface
Parameters:
- `DIV_RATIO`, 25, fast clocks per core enable; legal range ≥ 2
- `RST_HOLD`, 4, core_ce pulses issued with core_reset high; legal range ≥ 1
- `CNT_W`, 32, width of cycle_count

Ports:
- `clock`  in  1  fast clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `halt`  in  1  request to suppress core_ce (used only when STEP_MODE_EN is defined)
- `step`  in  1  rising edge requests one core_ce while halted (used only when STEP_MODE_EN is defined)
- `core_ce`  out  1  registered one-clock enable strobe for processor registers
- `core_reset`  out  1  registered, synchronous-deassert reset to processor
- `cycle_count`  out  CNT_W  core_ce pulses issued outside reset hold
- `state`  out  2  0=HOLD, 1=RUN, 2=HALTED

## Operation
- Divider: `div_cnt` counts 0..DIV_RATIO-1 and wraps. `tick` = (div_cnt == DIV_RATIO-1). The divider runs in all states.
- `core_ce` is registered and is 1 in the cycle after a tick edge when the tick is enabled:
  - HOLD: tick always enabled.
  - RUN: tick enabled when halt = 0.
  - HALTED: tick enabled only when step_pending = 1.
- FSM:
  - HOLD: `hold_cnt` counts issued pulses. On the edge that ends pulse number RST_HOLD, core_reset goes to 0 and the FSM moves to RUN.
  - RUN: when halt = 1 is sampled, the FSM moves to HALTED on that edge.
  - HALTED: when halt = 0 is sampled, the FSM moves to RUN.
  - Halt is ignored in HOLD.
- Step:
  - A step rising edge is detected against a registered `step_d`.
  - A step edge in HALTED sets `step_pending`. The next tick issues exactly one pulse and clears `step_pending`.
  - Step edges while `step_pending` = 1 are ignored.
  - halt falling clears `step_pending`.
- `cycle_count` increments on every edge where core_ce = 1 and state ≠ HOLD. It wraps modulo 2^CNT_W.
- Reset values: core_ce = 0, core_reset = 1, cycle_count = 0, state = HOLD, div_cnt = 0, hold_cnt = 0, step_pending = 0, step_d = 0.

## Timing
- Counting edges from reset deassertion (edge 1 is the first edge): tick edges are k·DIV_RATIO for k ≥ 1. core_ce is high from edge k·DIV_RATIO to edge k·DIV_RATIO+1.
- core_reset falls at edge RST_HOLD·DIV_RATIO+1. The processor therefore samples core_reset = 1 on exactly RST_HOLD enabled edges.
- Halt-to-suppression latency: halt sampled high at or before a tick edge suppresses that pulse.
- Step-to-pulse latency: the pulse appears at the next tick edge after step_pending is set, so at most DIV_RATIO+1 clocks.
- Simultaneous halt falling and step rising: halt wins. The FSM goes to RUN, step_pending stays 0, and normal pulses resume.
- Asynchronous reset mid-operation: all registers immediately return to their reset values, including an in-flight core_ce, which is cut short. Pulse phase restarts relative to the deassertion edge.
- Sequencing is unaffected by wrap of cycle_count.

## Configuration
- Macro `CORE_SEQ_STEP_MODE_EN`.
- Defined: halt and step behave as described above.
- Undefined:
  - halt and step are not connected internally.
  - The HALTED state and step_pending do not exist; state is never 2.
  - After HOLD, core_ce pulses on every tick.

## Test plan
All scenarios use DIV_RATIO=4, RST_HOLD=2, CNT_W=4 and CORE_SEQ_STEP_MODE_EN defined unless noted.
- Reset release, halt = 0 → core_ce high at edges 4, 8, 12, 16. core_reset falls at edge 9. cycle_count = 1 after edge 13, and 2 after edge 17.
- In RUN, halt = 1 from edge 18 to edge 30 → state = 2. No core_ce at edges 20, 24, 28. cycle_count frozen. Pulses resume at edge 32.
- HALTED, one step pulse at edge 21 → exactly one core_ce at edge 24 and cycle_count +1. A second step at edge 22 is ignored.
- Count 16 RUN pulses from cycle_count = 0 → cycle_count wraps to 0.
- reset asserted between edges 13 and 14 → core_ce = 0, core_reset = 1, cycle_count = 0, state = 0 immediately, before the next clock edge. Sequence restarts exactly as in scenario 1.
- Macro undefined, halt = 1 and step toggling throughout → same waveform as scenario 1, and state is never 2.
